// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Bit-counter width; never narrower than one bit so WIDTH=1 still has a counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and carry of three input bits.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through one full-adder cell.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] r_shift;

  fa_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New result bit enters at the MSB; written as shifts so WIDTH=1 needs no empty slice.
  always_comb begin
    r_shift = (r_sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  end

  // Next-state logic: operand capture, per-bit shifting and result publication.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StShift;
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          r_sr_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        // start is deliberately ignored here; operands stay as captured.
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        r_sr_d  = r_shift;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          sum_d   = r_shift;
          cout_d  = fa_cout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are flop values or decodes of the state flop only.
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n8, rst_n1;
  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  prev_sum;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n8),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse and push the expected result; returns at the negedge after acceptance.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    start8 = 1'b1;
    a8     = av;
    b8     = bv;
    cin8   = cv;
    exp_q.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cv});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Count busy cycles until done, checking the held result, then pop and compare.
  task automatic wait_done(input string tag, input bit full);
    int unsigned nbusy = 0;
    bit          held_ok = 1'b1;
    bit          seen = 1'b0;
    logic [8:0]  e;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        seen = 1'b1;
        break;
      end
      if (busy8) begin
        nbusy++;
        if (sum8 !== prev_sum) held_ok = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_busy_no_done"}, 32'(busy8), 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_sum"}, 32'(sum8), 32'(e[7:0]));
    check({tag, "_cout"}, 32'(cout8), 32'(e[8]));
    if (full) begin
      check({tag, "_busy_cycles"}, nbusy, 32'd8);
      check({tag, "_held"}, 32'(held_ok), 32'd1);
    end
    prev_sum = e[7:0];
  endtask

  initial begin
    bit saw_done;
    rst_n8 = 1'b0; rst_n1 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    prev_sum = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    rst_n8 = 1'b1; rst_n1 = 1'b1;

    // Carry ripples through every bit.
    launch(8'hFF, 8'h01, 1'b0);
    wait_done("ff_01", 1'b1);
    @(negedge clk);
    check("ff_01_done_pulse", 32'(done8), 32'd0);

    launch(8'h5A, 8'h35, 1'b1);
    wait_done("5a_35", 1'b1);
    check("5a_35_lit_sum", 32'(sum8), 32'h90);

    // start held through SHIFT with zeroed operands; DONE then relaunches with those zeros.
    launch(8'h12, 8'h34, 1'b1);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    wait_done("hold_start", 1'b1);
    exp_q.push_back(9'd0);
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_busy_next", 32'(busy8), 32'd1);
    check("b2b_done_low", 32'(done8), 32'd0);
    wait_done("b2b", 1'b1);

    // Reset mid-operation discards the partial result.
    launch(8'h77, 8'h22, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n8 = 1'b0;
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_sum", 32'(sum8), 32'd0);
    check("midrst_cout", 32'(cout8), 32'd0);
    void'(exp_q.pop_back());
    prev_sum = 8'h00;
    saw_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 1) rst_n8 = 1'b1;
      if (done8 || busy8) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    launch(8'h0F, 8'hF0, 1'b1);
    wait_done("after_rst", 1'b1);

    // WIDTH=1: one SHIFT cycle then DONE.
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("w1_busy", 32'(busy1), 32'd1);
    check("w1_done_early", 32'(done1), 32'd0);
    @(negedge clk);
    check("w1_busy_off", 32'(busy1), 32'd0);
    check("w1_done", 32'(done1), 32'd1);
    check("w1_sum", 32'(sum1), 32'd1);
    check("w1_cout", 32'(cout1), 32'd1);
    @(negedge clk);
    check("w1_done_pulse", 32'(done1), 32'd0);

    // Random operands against a + b + cin.
    for (int k = 0; k < 200; k++) begin
      launch(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      wait_done("rand", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
